// File: rtl/keypad_entry_unit.sv
// keypad_entry_unit: 4x4 matrix keypad scanner with debounce, a BCD
// number-entry buffer and a sequential BCD-to-binary converter with a
// range check, producing a WIDTH-bit two's-complement operand.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   row[3:0]        keypad rows, active-low (pulled up)
//   col[3:0]        column drive, active-low one-hot
//   load            external Enter level, sampled while not busy
//   bcd[4*DIGITS]   entered digits, LSD in [3:0], blank = 4'hF
//   neg             sign flag
//   key_strobe      one-cycle pulse per accepted key
//   busy            conversion in progress
//   bin             converted result
//   bin_valid       one-cycle pulse when bin/overflow update
//   overflow        last conversion was out of range
//
// Optional feature macro: SAT_ON_OVF_EN
//   defined   -> bin saturates to the signed limit on overflow
//   undefined -> bin is forced to 0 on overflow
//
// Rows pass through a two-flop synchronizer, so a freshly driven
// column is only sampled from the third cycle of its dwell onward;
// SCAN_DIV should be at least 3.

module keypad_entry_unit #(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          row,
    output logic [3:0]          col,
    input  logic                load,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic                key_strobe,
    output logic                busy,
    output logic [WIDTH-1:0]    bin,
    output logic                bin_valid,
    output logic                overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ACC_W = WIDTH + 4;
    localparam int MAC_W = ACC_W + 4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] SETTLE   = DIV_W'(2);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIGITS);
    localparam logic [IDX_W-1:0] IDX_MSD  = IDX_W'(DIGITS - 1);

    localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(1) << (WIDTH - 1);
    localparam logic [ACC_W-1:0] POS_LIM = NEG_LIM - ACC_W'(1);

    localparam logic [4*DIGITS-1:0] BLANK = {(4*DIGITS){1'b1}};
    localparam logic [4*DIGITS-1:0] TOP_F = ~(BLANK >> 4);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } scan_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_CONV,
        C_CHECK
    } conv_t;

    typedef enum logic [2:0] {
        K_DIGIT,
        K_SIGN,
        K_CLEAR,
        K_BKSP,
        K_ENTER,
        K_NOP
    } key_t;

    // ---------------- row synchronizer ----------------
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // ---------------- row/col encoders ----------------
    // Descending loops so the lowest active index wins.
    logic       row_hit;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic [3:0] cur_code;

    always_comb begin
        row_hit = (row_sync != 4'hF);
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) row_idx = 2'(r);
        end
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col[c]) col_idx = 2'(c);
        end
        cur_code = {row_idx, col_idx};
    end

    // ---------------- scan FSM ----------------
    scan_t           scan_state;
    logic [DIV_W-1:0] div_cnt;
    logic [DB_W-1:0]  db_cnt;
    logic [3:0]       code;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_state <= S_SCAN;
            col        <= 4'b1110;
            div_cnt    <= '0;
            db_cnt     <= '0;
            code       <= 4'h0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (scan_state)
                S_SCAN: begin
                    if (row_hit && div_cnt >= SETTLE) begin
                        code       <= cur_code;
                        db_cnt     <= '0;
                        scan_state <= S_DEBOUNCE;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        col     <= {col[2:0], col[3]};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!row_hit || cur_code != code) begin
                        div_cnt    <= '0;
                        scan_state <= S_SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key_strobe <= 1'b1;
                        scan_state <= S_PRESSED;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    db_cnt     <= '0;
                    scan_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (row_hit) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        div_cnt    <= '0;
                        scan_state <= S_SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: scan_state <= S_SCAN;
            endcase
        end
    end

    // ---------------- key decode ----------------
    // code = {row, col}; r0: 1 2 3 A, r1: 4 5 6 B,
    // r2: 7 8 9 C, r3: * 0 # D
    key_t       key_kind;
    logic [3:0] key_val;
    logic       key_fire;

    assign key_fire = (scan_state == S_PRESSED);

    always_comb begin
        key_kind = K_DIGIT;
        key_val  = 4'd0;
        case (code)
            4'h0: key_val  = 4'd1;
            4'h1: key_val  = 4'd2;
            4'h2: key_val  = 4'd3;
            4'h3: key_kind = K_SIGN;
            4'h4: key_val  = 4'd4;
            4'h5: key_val  = 4'd5;
            4'h6: key_val  = 4'd6;
            4'h7: key_kind = K_NOP;
            4'h8: key_val  = 4'd7;
            4'h9: key_val  = 4'd8;
            4'hA: key_val  = 4'd9;
            4'hB: key_kind = K_CLEAR;
            4'hC: key_kind = K_BKSP;
            4'hD: key_val  = 4'd0;
            4'hE: key_kind = K_ENTER;
            default: key_kind = K_NOP;
        endcase
    end

    // ---------------- conversion datapath ----------------
    conv_t            conv_state;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;
    logic             carry;

    logic [3:0]       cur_digit;
    logic [MAC_W-1:0] mac;

    // Blank digits (F) contribute zero.
    always_comb begin
        cur_digit = bcd[{idx, 2'b00} +: 4];
        if (cur_digit > 4'd9) cur_digit = 4'd0;
        mac = (MAC_W'(acc) << 3)
            + (MAC_W'(acc) << 1)
            + MAC_W'(cur_digit);
    end

    logic [ACC_W-1:0] limit;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] ovf_bin;
    logic             out_of_range;

    always_comb begin
        limit        = neg ? NEG_LIM : POS_LIM;
        mag          = acc[WIDTH-1:0];
        result       = neg ? (WIDTH'(0) - mag) : mag;
        out_of_range = carry || (acc > limit);
`ifdef SAT_ON_OVF_EN
        ovf_bin = neg ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
`else
        ovf_bin = '0;
`endif
    end

    logic enter;
    assign enter = load || (key_fire && key_kind == K_ENTER);

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_state <= C_IDLE;
            bcd        <= BLANK;
            count      <= '0;
            neg        <= 1'b0;
            busy       <= 1'b0;
            idx        <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            bin        <= '0;
            bin_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            case (conv_state)
                C_IDLE: begin
                    if (enter) begin
                        busy       <= 1'b1;
                        acc        <= '0;
                        carry      <= 1'b0;
                        idx        <= IDX_MSD;
                        conv_state <= C_CONV;
                    end else if (key_fire) begin
                        case (key_kind)
                            K_DIGIT: begin
                                if (count < CNT_MAX) begin
                                    bcd   <= (bcd << 4)
                                           | (4*DIGITS)'(key_val);
                                    count <= count + 1'b1;
                                end
                            end
                            K_BKSP: begin
                                if (count != '0) begin
                                    bcd   <= (bcd >> 4) | TOP_F;
                                    count <= count - 1'b1;
                                end
                            end
                            K_CLEAR: begin
                                bcd   <= BLANK;
                                count <= '0;
                                neg   <= 1'b0;
                            end
                            K_SIGN: neg <= ~neg;
                            default: ;
                        endcase
                    end
                end
                C_CONV: begin
                    acc <= mac[ACC_W-1:0];
                    if (mac[MAC_W-1:ACC_W] != 4'd0) carry <= 1'b1;
                    if (idx == '0) conv_state <= C_CHECK;
                    else           idx <= idx - 1'b1;
                end
                C_CHECK: begin
                    busy       <= 1'b0;
                    bin_valid  <= 1'b1;
                    conv_state <= C_IDLE;
                    if (out_of_range) begin
                        overflow <= 1'b1;
                        bin      <= ovf_bin;
                    end else begin
                        overflow <= 1'b0;
                        bin      <= result;
                    end
                end
                default: conv_state <= C_IDLE;
            endcase
        end
    end

endmodule
